// File: rtl/score4_input_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score4_input_cond                                                        |
// | Synchronises, debounces, arbitrates and locks out the Score4 buttons,    |
// | emitting exclusive one-cycle left/right/put command pulses.              |
// | Optional macro SCORE4_AUTOREPEAT_EN adds left/right auto-repeat.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module score4_input_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  input  logic put_raw,
  input  logic game_over,
  output logic left,
  output logic right,
  output logic put,
  output logic dropped
);

  localparam int c_CW = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("score4_input_cond: timing parameters must be at least 2");
  end

  // Button index: 0 = left, 1 = right, 2 = put
  logic [2:0] w_raw;
  logic [2:0] w_press;
  logic [1:0] w_rpt;

  assign w_raw = {put_raw, right_raw, left_raw};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic [1:0]      r_sync;
    logic [c_CW-1:0] r_cnt;
    logic            r_deb;
    logic            r_deb_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[g]};
        r_deb_q <= r_deb;
        if (r_sync[1] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CW'(1);
        end
      end
    end

    assign w_press[g] = r_deb & ~r_deb_q;
  end

`ifdef SCORE4_AUTOREPEAT_EN
  localparam int c_RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rpt_state_t;

  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_t      r_state;
    logic [c_RW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (!g_btn[g].r_deb || game_over) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_press[g]) begin
              r_state <= S_DELAY;
              r_cnt   <= '0;
            end
          end
          S_DELAY: begin
            if (r_cnt == c_RW'(REPEAT_DELAY - 1)) begin
              r_state <= S_REPEAT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_RW'(1);
            end
          end
          S_REPEAT: begin
            if (r_cnt == c_RW'(REPEAT_PERIOD - 1)) r_cnt <= '0;
            else                                   r_cnt <= r_cnt + c_RW'(1);
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    // Gated by deb so a repeat cannot fire in the cycle the release is accepted
    assign w_rpt[g] = g_btn[g].r_deb &&
                      (((r_state == S_DELAY)  && (r_cnt == c_RW'(REPEAT_DELAY - 1))) ||
                       ((r_state == S_REPEAT) && (r_cnt == c_RW'(REPEAT_PERIOD - 1))));
  end
`else
  assign w_rpt = 2'b00;
`endif

  logic w_left_evt;
  logic w_right_evt;
  logic w_put_evt;

  assign w_left_evt  = w_press[0] | w_rpt[0];
  assign w_right_evt = w_press[1] | w_rpt[1];
  assign w_put_evt   = w_press[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left    <= 1'b0;
      right   <= 1'b0;
      put     <= 1'b0;
      dropped <= 1'b0;
    end else begin
      right   <= !game_over && w_right_evt;
      left    <= !game_over && w_left_evt && !w_right_evt;
      put     <= !game_over && w_put_evt && !w_left_evt && !w_right_evt;
      dropped <= !game_over && ((w_right_evt && (w_left_evt || w_put_evt)) ||
                                (w_left_evt && w_put_evt));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score4_input_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_score4_input_cond                                                     |
// | Directed self-checking bench for score4_input_cond (D=4, RD=8, RP=3).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_score4_input_cond;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic left_raw  = 1'b0;
  logic right_raw = 1'b0;
  logic put_raw   = 1'b0;
  logic game_over = 1'b0;
  logic left;
  logic right;
  logic put;
  logic dropped;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output encoding {left, right, put, dropped}
  localparam logic [3:0] c_Z = 4'b0000;
  localparam logic [3:0] c_L = 4'b1000;
  localparam logic [3:0] c_R = 4'b0100;
  localparam logic [3:0] c_P = 4'b0010;
  localparam logic [3:0] c_D = 4'b0001;

`ifdef SCORE4_AUTOREPEAT_EN
  localparam bit c_AR = 1'b1;
`else
  localparam bit c_AR = 1'b0;
`endif

  score4_input_cond #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .left_raw (left_raw),
    .right_raw(right_raw),
    .put_raw  (put_raw),
    .game_over(game_over),
    .left     (left),
    .right    (right),
    .put      (put),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {left, right, put, dropped};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed lrpd=%b expected lrpd=%b", tag, k, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp;

    // Reset state
    tick();
    check("reset", 0, c_Z);
    tick();
    rst = 1'b0;
    check("reset_release", 0, c_Z);

    // Clean right press, held 20 cycles then released
    right_raw = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 20) right_raw = 1'b0;
      exp = (k == 7 || (c_AR && (k == 15 || k == 18 || k == 21 || k == 24))) ? c_R : c_Z;
      check("clean_right", k, exp);
    end

    // Bouncing put: 1,0,1,0 every 2 cycles, stable high from step 8
    put_raw = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 2 || k == 6) put_raw = 1'b0;
      if (k == 4 || k == 8) put_raw = 1'b1;
      if (k == 22)          put_raw = 1'b0;
      exp = (k == 15) ? c_P : c_Z;
      check("bounce_put", k, exp);
    end

    // Left held: repeats at 15,18,21,24,27 when auto-repeat is built in
    left_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 22) left_raw = 1'b0;
      exp = (k == 7 || (c_AR && (k == 15 || k == 18 || k == 21 || k == 24 || k == 27))) ? c_L : c_Z;
      check("repeat_left", k, exp);
    end

    // Simultaneous left and right: right wins, dropped flags the lost left
    left_raw  = 1'b1;
    right_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) begin
        left_raw  = 1'b0;
        right_raw = 1'b0;
      end
      exp = (k == 7) ? (c_R | c_D) : c_Z;
      check("simul_lr", k, exp);
    end

    // Lockout: press during game_over, clear while held, release, re-press
    game_over = 1'b1;
    put_raw   = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (k == 12) game_over = 1'b0;
      if (k == 20) put_raw   = 1'b0;
      if (k == 30) put_raw   = 1'b1;
      if (k == 40) put_raw   = 1'b0;
      exp = (k == 37) ? c_P : c_Z;
      check("lockout_put", k, exp);
    end

    // game_over high exactly on the edge the pulse would register
    right_raw = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 6)  game_over = 1'b1;
      if (k == 7)  game_over = 1'b0;
      if (k == 10) right_raw = 1'b0;
      check("lockout_edge", k, c_Z);
    end

    // Reset mid-debounce: held right is a new press after reset release
    right_raw = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_debounce", 3, c_Z);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = (k == 7) ? c_R : c_Z;
      check("rst_repress", k, exp);
    end

    // Reset while a pulse is high clears it asynchronously
    rst = 1'b1;
    #1;
    check("rst_clears_pulse", 7, c_Z);
    tick();
    tick();
    rst       = 1'b0;
    right_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("rst_idle", k, c_Z);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
